// File: rtl/pipeline_forward_net.sv
// Operand bypass network: resolves each read port against the EX stage and a
// short history of retired results, and flags a hazard on pending (load) results.
module pipeline_forward_net #(
  parameter int NUM_RD     = 2,
  parameter int HIST_DEPTH = 2,
  parameter int DATA_W     = 32,
  parameter int IDX_W      = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     advance,
  input  logic                     flush,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*IDX_W-1:0]  rd_idx,
  input  logic [NUM_RD*DATA_W-1:0] rf_val,
  input  logic                     ex_wr_en,
  input  logic [IDX_W-1:0]         ex_wr_idx,
  input  logic [DATA_W-1:0]        ex_wr_val,
  input  logic                     ex_pending,
  input  logic                     late_en,
  input  logic [DATA_W-1:0]        late_val,
  output logic [NUM_RD*DATA_W-1:0] fwd_val,
  output logic [NUM_RD-1:0]        fwd_hit,
  output logic                     hazard
);

  logic [HIST_DEPTH-1:0] h_valid;
  logic [HIST_DEPTH-1:0] h_pend;
  logic [IDX_W-1:0]      h_idx [HIST_DEPTH];
  logic [DATA_W-1:0]     h_val [HIST_DEPTH];

  logic                  fill;
  logic [HIST_DEPTH-1:0] cur_pend;
  logic [DATA_W-1:0]     cur_val [HIST_DEPTH];
  logic [NUM_RD-1:0]     port_haz;

  // The late fill is applied to entry 0 before any shift, so a concurrent
  // advance carries the filled value into entry 1.
  assign fill = late_en && h_valid[0] && h_pend[0];

  always_comb begin
    cur_pend    = h_pend;
    cur_val     = h_val;
    cur_pend[0] = h_pend[0] & ~fill;
    cur_val[0]  = fill ? late_val : h_val[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_valid <= '0;
      h_pend  <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        h_idx[i] <= '0;
        h_val[i] <= '0;
      end
    end else if (flush) begin
      h_valid <= '0;
      h_pend  <= '0;
    end else if (advance) begin
      h_valid[0] <= ex_wr_en && (ex_wr_idx != '0);
      h_pend[0]  <= ex_pending;
      h_idx[0]   <= ex_wr_idx;
      h_val[0]   <= ex_wr_val;
      for (int i = 1; i < HIST_DEPTH; i++) begin
        h_valid[i] <= h_valid[i-1];
        h_pend[i]  <= cur_pend[i-1];
        h_idx[i]   <= h_idx[i-1];
        h_val[i]   <= cur_val[i-1];
      end
    end else if (fill) begin
      h_pend[0] <= 1'b0;
      h_val[0]  <= late_val;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [IDX_W-1:0]  idx;
    logic              found;
    logic              pend;
    logic [DATA_W-1:0] val;

    assign idx = rd_idx[p*IDX_W +: IDX_W];

    // Oldest-to-newest scan so the newest matching entry overrides; EX beats all.
    always_comb begin
      found = 1'b0;
      pend  = 1'b0;
      val   = '0;
      if (idx != '0) begin
        if (ex_wr_en && (ex_wr_idx == idx)) begin
          found = 1'b1;
          pend  = ex_pending;
          val   = ex_wr_val;
        end else begin
          for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
            if (h_valid[i] && (h_idx[i] == idx)) begin
              found = 1'b1;
              pend  = h_pend[i];
              val   = h_val[i];
            end
          end
        end
      end
    end

    assign fwd_hit[p]  = found && !pend;
    assign port_haz[p] = rd_en[p] && found && pend;
    assign fwd_val[p*DATA_W +: DATA_W] = (idx == '0)       ? '0  :
                                         (found && !pend)  ? val :
                                         rf_val[p*DATA_W +: DATA_W];
  end

  assign hazard = |port_haz;

endmodule

// File: tb/tb_pipeline_forward_net.sv
// Directed bench for pipeline_forward_net: vector table plus reset sequences.
module tb_pipeline_forward_net;

  localparam logic [31:0] RF0 = 32'h0000_A0A0;
  localparam logic [31:0] RF1 = 32'h0000_B0B0;

  logic        clk;
  logic        rst;
  logic        advance;
  logic        flush;
  logic [1:0]  rd_en;
  logic [9:0]  rd_idx;
  logic [63:0] rf_val;
  logic        ex_wr_en;
  logic [4:0]  ex_wr_idx;
  logic [31:0] ex_wr_val;
  logic        ex_pending;
  logic        late_en;
  logic [31:0] late_val;
  logic [63:0] fwd_val;
  logic [1:0]  fwd_hit;
  logic        hazard;

  int pass_cnt;
  int total_cnt;

  typedef struct {
    logic        adv;
    logic        fl;
    logic [1:0]  en;
    logic [4:0]  i0;
    logic [4:0]  i1;
    logic        ex_en;
    logic [4:0]  ex_idx;
    logic [31:0] ex_val;
    logic        ex_pend;
    logic        late;
    logic [31:0] lval;
    logic [31:0] e_f0;
    logic [31:0] e_f1;
    logic [1:0]  e_hit;
    logic        e_haz;
  } vec_t;

  vec_t vecs [20];

  pipeline_forward_net #(
    .NUM_RD(2), .HIST_DEPTH(2), .DATA_W(32), .IDX_W(5)
  ) dut (
    .clk(clk), .rst(rst), .advance(advance), .flush(flush),
    .rd_en(rd_en), .rd_idx(rd_idx), .rf_val(rf_val),
    .ex_wr_en(ex_wr_en), .ex_wr_idx(ex_wr_idx), .ex_wr_val(ex_wr_val),
    .ex_pending(ex_pending), .late_en(late_en), .late_val(late_val),
    .fwd_val(fwd_val), .fwd_hit(fwd_hit), .hazard(hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    advance    = v.adv;
    flush      = v.fl;
    rd_en      = v.en;
    rd_idx     = {v.i1, v.i0};
    ex_wr_en   = v.ex_en;
    ex_wr_idx  = v.ex_idx;
    ex_wr_val  = v.ex_val;
    ex_pending = v.ex_pend;
    late_en    = v.late;
    late_val   = v.lval;
  endtask

  task automatic checkVec(input string tag, input logic [31:0] f0, input logic [31:0] f1,
                          input logic [1:0] hit, input logic haz);
    checkOutput({tag, " fwd0"}, fwd_val[31:0], f0);
    checkOutput({tag, " fwd1"}, fwd_val[63:32], f1);
    checkOutput({tag, " hit"}, {30'd0, fwd_hit}, {30'd0, hit});
    checkOutput({tag, " hazard"}, {31'd0, hazard}, {31'd0, haz});
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rf_val    = {RF1, RF0};

    //           adv fl en     i0 i1 exen exidx exval         pend late lval          f0            f1            hit   haz
    vecs[0]  = '{0, 0, 2'b11, 5, 7, 0, 0, 32'h0,        0, 0, 32'h0,  RF0,          RF1,          2'b00, 0};
    vecs[1]  = '{0, 0, 2'b11, 3, 0, 1, 3, 32'h11,       0, 0, 32'h0,  32'h11,       32'h0,        2'b01, 0};
    vecs[2]  = '{1, 0, 2'b11, 5, 5, 1, 5, 32'hA,        0, 0, 32'h0,  32'hA,        32'hA,        2'b11, 0};
    vecs[3]  = '{1, 0, 2'b11, 5, 6, 1, 5, 32'hB,        0, 0, 32'h0,  32'hB,        RF1,          2'b01, 0};
    vecs[4]  = '{1, 0, 2'b11, 5, 4, 0, 0, 32'h0,        0, 0, 32'h0,  32'hB,        RF1,          2'b01, 0};
    vecs[5]  = '{0, 0, 2'b11, 5, 5, 0, 0, 32'h0,        0, 0, 32'h0,  32'hB,        32'hB,        2'b11, 0};
    vecs[6]  = '{1, 0, 2'b11, 3, 0, 1, 0, 32'h99,       0, 0, 32'h0,  RF0,          32'h0,        2'b00, 0};
    vecs[7]  = '{0, 0, 2'b11, 0, 5, 0, 0, 32'h0,        0, 0, 32'h0,  32'h0,        RF1,          2'b00, 0};
    vecs[8]  = '{0, 0, 2'b10, 7, 7, 1, 7, 32'hDEAD,     1, 0, 32'h0,  RF0,          RF1,          2'b00, 1};
    vecs[9]  = '{1, 0, 2'b00, 7, 7, 1, 7, 32'hDEAD,     1, 0, 32'h0,  RF0,          RF1,          2'b00, 0};
    vecs[10] = '{0, 0, 2'b10, 7, 7, 0, 0, 32'h0,        0, 1, 32'h55, RF0,          RF1,          2'b00, 1};
    vecs[11] = '{0, 0, 2'b11, 7, 7, 0, 0, 32'h0,        0, 1, 32'h77, 32'h55,       32'h55,       2'b11, 0};
    vecs[12] = '{1, 0, 2'b01, 7, 7, 1, 7, 32'hBAD,      1, 0, 32'h0,  RF0,          RF1,          2'b00, 1};
    vecs[13] = '{1, 0, 2'b11, 7, 7, 0, 0, 32'h0,        0, 1, 32'h66, RF0,          RF1,          2'b00, 1};
    vecs[14] = '{0, 0, 2'b11, 7, 7, 0, 0, 32'h0,        0, 0, 32'h0,  32'h66,       32'h66,       2'b11, 0};
    vecs[15] = '{1, 0, 2'b01, 9, 7, 1, 9, 32'h0,        1, 0, 32'h0,  RF0,          32'h66,       2'b10, 1};
    vecs[16] = '{1, 0, 2'b11, 9, 9, 1, 9, 32'h1234,     0, 0, 32'h0,  32'h1234,     32'h1234,     2'b11, 0};
    vecs[17] = '{0, 0, 2'b11, 9, 9, 0, 0, 32'h0,        0, 0, 32'h0,  32'h1234,     32'h1234,     2'b11, 0};
    vecs[18] = '{1, 1, 2'b11, 9, 9, 1, 9, 32'h4,        0, 1, 32'h5,  32'h4,        32'h4,        2'b11, 0};
    vecs[19] = '{0, 0, 2'b11, 9, 7, 0, 0, 32'h0,        0, 0, 32'h0,  RF0,          RF1,          2'b00, 0};

    rst = 1'b1;
    applyStimulus(vecs[0]);
    #12;
    checkVec("in_reset", RF0, RF1, 2'b00, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      applyStimulus(vecs[k]);
      #2;
      checkVec($sformatf("v%0d", k), vecs[k].e_f0, vecs[k].e_f1, vecs[k].e_hit, vecs[k].e_haz);
    end

    // Mid-cycle async reset with a pending entry that a later fill must not revive.
    @(negedge clk);
    applyStimulus('{1, 0, 2'b00, 0, 0, 1, 4, 32'h44, 0, 0, 32'h0, 0, 0, 0, 0});
    @(negedge clk);
    applyStimulus('{1, 0, 2'b00, 0, 0, 1, 8, 32'h0, 1, 0, 32'h0, 0, 0, 0, 0});
    @(negedge clk);
    applyStimulus('{0, 0, 2'b11, 4, 8, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0});
    #1;
    checkVec("pre_rst", 32'h44, RF1, 2'b01, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    checkVec("async_rst", RF0, RF1, 2'b00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    late_en  = 1'b1;
    late_val = 32'h88;
    @(negedge clk);
    late_en = 1'b0;
    #2;
    checkVec("post_rst_fill", RF0, RF1, 2'b00, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
